// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Size encodings mirror the EX/MEM request format; widths mirror RegBus/DmAddr.
package mem_access_unit_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 14;
  localparam int DM_SIZE_DEF = 16384;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_RMW_WR
  } state_t;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane handling: extract+extend a byte/half for loads, and merge
// store data into the selected lane of a read word for read-modify-write.
module mem_access_unit_lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        size_i,
  input  logic              sign_i,
  input  logic [1:0]        off_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = word_i[{off_i[1], 4'b0000} +: 16];

    load_o = word_i;
    unique case (size_i)
      SZ_BYTE: load_o = {{(DATA_W-8){sign_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_o = {{(DATA_W-16){sign_i & half_sel[15]}}, half_sel};
      default: load_o = word_i;
    endcase

    merge_o = word_i;
    unique case (size_i)
      SZ_BYTE: merge_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_HALF: merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte/half/word requests to a word-wide DM port,
// sub-word stores as a two-cycle read-modify-write, registered responses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DM_SIZE = DM_SIZE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              DM_read,
  output logic              DM_write,
  output logic [ADDR_W-1:0] DM_addr,
  output logic [DATA_W-1:0] DM_in,
  input  logic [DATA_W-1:0] DM_out
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] merged_q, merged_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              accept;
  logic              req_err;
  logic              out_of_range;
  logic [31:0]       word_idx;
  logic [ADDR_W-1:0] req_idx;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merge_val;

  mem_access_unit_lane_align #(.DATA_W(DATA_W)) u_lane (
    .word_i  (DM_out),
    .wdata_i (req_wdata),
    .size_i  (req_size),
    .sign_i  (req_signed),
    .off_i   (req_addr[1:0]),
    .load_o  (load_val),
    .merge_o (merge_val)
  );

  assign word_idx     = {2'b00, req_addr[31:2]};
  assign req_idx      = req_addr[ADDR_W+1:2];
  // The full byte address is range-checked, not just the bits that reach DM_addr.
  assign out_of_range = (word_idx >= 32'(DM_SIZE));
  assign req_err      = (req_load == req_store)
                      | (req_size == SZ_ILL)
                      | ((req_size == SZ_HALF) & req_addr[0])
                      | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00))
                      | out_of_range;

  assign req_ready = (state_q == ST_IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    merged_d    = merged_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    DM_read     = 1'b0;
    DM_write    = 1'b0;
    DM_addr     = '0;
    DM_in       = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (req_load) begin
            DM_read     = 1'b1;
            DM_addr     = req_idx;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_val;
          end else if (req_size == SZ_WORD) begin
            DM_write    = 1'b1;
            DM_addr     = req_idx;
            DM_in       = req_wdata;
            rsp_valid_d = 1'b1;
          end else begin
            // Sub-word store: read now, write the merged word next cycle.
            DM_read  = 1'b1;
            DM_addr  = req_idx;
            merged_d = merge_val;
            idx_d    = req_idx;
            state_d  = ST_RMW_WR;
          end
        end
      end
      ST_RMW_WR: begin
        DM_write    = 1'b1;
        DM_addr     = idx_q;
        DM_in       = merged_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      merged_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      merged_q    <= merged_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural DM model and a
// response scoreboard; expected responses are queued when requests are accepted.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 14;
  localparam int DMS = 16384;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid, req_ready, req_load, req_store, req_signed;
  logic [1:0]    req_size;
  logic [31:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          DM_read, DM_write;
  logic [AW-1:0] DM_addr;
  logic [DW-1:0] DM_in, DM_out;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .DM_SIZE(DMS)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_load   (req_load),
    .req_store  (req_store),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .DM_read    (DM_read),
    .DM_write   (DM_write),
    .DM_addr    (DM_addr),
    .DM_in      (DM_in),
    .DM_out     (DM_out)
  );

  // Behavioural data memory with a backdoor preload port.
  logic [DW-1:0] mem [0:DMS-1];
  logic          bk_we;
  logic [AW-1:0] bk_a;
  logic [DW-1:0] bk_d;

  always @(posedge clk) begin
    if (bk_we) mem[bk_a] <= bk_d;
    else if (DM_write) mem[DM_addr] <= DM_in;
  end
  assign DM_out = DM_read ? mem[DM_addr] : '0;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;
  rsp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && rsp_valid) begin
      rsp_t e;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_rsp: observed err=%b rdata=%h expected no response", rsp_err, rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err",   {31'b0, rsp_err}, {31'b0, e.err});
        check("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  always @(negedge clk) begin
    if (DM_read || DM_write) check("strobe_excl", {31'b0, DM_read & DM_write}, 32'd0);
  end

  // Called just after a falling edge; returns on the falling edge after acceptance.
  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rdata,
                       input logic exp_rd, input logic exp_wr);
    req_valid  = 1'b1;
    req_load   = ld;
    req_store  = st;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    for (int n = 0; n < 20 && !req_ready; n++) @(negedge clk);
    if (!req_ready) begin
      tests++;
      fails++;
      $error("FAIL ready_timeout: observed req_ready=0 expected 1 within 20 cycles");
    end
    exp_q.push_back({exp_err, exp_rdata});
    #1;
    check("acc_DM_read",  {31'b0, DM_read},  {31'b0, exp_rd});
    check("acc_DM_write", {31'b0, DM_write}, {31'b0, exp_wr});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_valid = 0; req_load = 0; req_store = 0; req_size = 0;
    req_signed = 0; req_addr = 0; req_wdata = 0;
    bk_we = 1'b1; bk_a = 14'd0; bk_d = 32'h8899AABB;
    @(negedge clk);
    bk_a = 14'd1; bk_d = 32'hDEADBEEF;
    @(negedge clk);
    bk_a = 14'd2; bk_d = 32'h11223344;
    @(negedge clk);
    bk_we = 1'b0;

    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_DM_read",   {31'b0, DM_read},   32'd0);
    check("rst_DM_write",  {31'b0, DM_write},  32'd0);
    check("rst_DM_addr",   {18'b0, DM_addr},   32'd0);
    check("rst_DM_in",     DM_in, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);

    // Loads with lane selection and extension
    issue(1, 0, SZ_BYTE, 1, 32'h1, 32'h0, 0, 32'hFFFFFFAA, 1, 0);
    issue(1, 0, SZ_BYTE, 0, 32'h1, 32'h0, 0, 32'h000000AA, 1, 0);
    issue(1, 0, SZ_HALF, 0, 32'h2, 32'h0, 0, 32'h00008899, 1, 0);
    issue(1, 0, SZ_HALF, 1, 32'h2, 32'h0, 0, 32'hFFFF8899, 1, 0);
    issue(1, 0, SZ_WORD, 0, 32'h0, 32'h0, 0, 32'h8899AABB, 1, 0);

    // Half store read-modify-write; upper store bits must be ignored
    issue(0, 1, SZ_HALF, 0, 32'h6, 32'hABCD1234, 0, 32'h0, 1, 0);
    #1;
    check("rmw_req_ready", {31'b0, req_ready}, 32'd0);
    check("rmw_DM_write",  {31'b0, DM_write},  32'd1);
    check("rmw_DM_read",   {31'b0, DM_read},   32'd0);
    check("rmw_DM_addr",   {18'b0, DM_addr},   32'd1);
    check("rmw_DM_in",     DM_in, 32'h1234BEEF);
    @(negedge clk);
    #1;
    check("rmw_ready_back", {31'b0, req_ready}, 32'd1);
    check("mem_word1",      mem[1], 32'h1234BEEF);
    @(negedge clk);

    // Word store then back-to-back load of the same word
    issue(0, 1, SZ_WORD, 0, 32'h10, 32'hCAFEF00D, 0, 32'h0, 0, 1);
    check("b2b_no_stall", {31'b0, req_ready}, 32'd1);
    issue(1, 0, SZ_WORD, 0, 32'h10, 32'h0, 0, 32'hCAFEF00D, 1, 0);

    // Rejected requests: no strobes, error response with zero data
    issue(1, 0, SZ_WORD, 0, 32'h2, 32'h0, 1, 32'h0, 0, 0);
    issue(0, 1, SZ_HALF, 0, 32'h3, 32'h77, 1, 32'h0, 0, 0);
    issue(1, 0, SZ_ILL,  0, 32'h0, 32'h0, 1, 32'h0, 0, 0);
    issue(1, 1, SZ_WORD, 0, 32'h0, 32'h0, 1, 32'h0, 0, 0);
    issue(0, 0, SZ_WORD, 0, 32'h0, 32'h0, 1, 32'h0, 0, 0);
    issue(1, 0, SZ_WORD, 0, 32'(DMS * 4), 32'h0, 1, 32'h0, 0, 0);
    issue(1, 0, SZ_WORD, 0, 32'((DMS - 1) * 4), 32'h0, 0, mem[DMS-1], 1, 0);
    @(negedge clk);

    // Reset during the write phase of a byte store
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_size = SZ_BYTE;
    req_signed = 1'b0; req_addr = 32'h9; req_wdata = 32'h55;
    #1;
    check("rstw_DM_read", {31'b0, DM_read}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("rstw_DM_write_pre", {31'b0, DM_write}, 32'd1);
    rst = 1'b0;
    #1;
    check("rstw_DM_write",  {31'b0, DM_write},  32'd0);
    check("rstw_DM_read",   {31'b0, DM_read},   32'd0);
    check("rstw_DM_in",     DM_in, 32'd0);
    check("rstw_DM_addr",   {18'b0, DM_addr},   32'd0);
    check("rstw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rstw_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("rstw_mem_word2",   mem[2], 32'h11223344);
    check("rstw_no_response", {31'b0, rsp_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    issue(0, 1, SZ_BYTE, 0, 32'h9, 32'h55, 0, 32'h0, 1, 0);
    @(negedge clk);
    check("post_rst_mem_word2", mem[2], 32'h11225544);
    issue(1, 0, SZ_BYTE, 1, 32'h9, 32'h0, 0, 32'h00000055, 1, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit of the pipeline; sits between the EX/MEM pipeline register and the word-wide data memory.
- Converts byte/halfword/word load and store requests into word accesses on the DM port.
- Sub-word stores use a two-cycle read-modify-write.
- Returns aligned, sign- or zero-extended load data one cycle after acceptance and flags misaligned or out-of-range accesses.

Parameters:
- DATA_W, 32, data word width (matches RegBus).
- ADDR_W, 14, DM word-address width (matches DmAddr).
- DM_SIZE, 16384, number of DM words; word indices >= DM_SIZE are out of range.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present from EX/MEM.
- req_ready  out  1  unit can accept a request this cycle.
- req_load  in  1  load request.
- req_store  in  1  store request.
- req_size  in  2  0=byte, 1=half, 2=word; 3 is illegal.
- req_signed  in  1  sign-extend load result.
- req_addr  in  32  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse: request completed.
- rsp_err  out  1  qualifies rsp_valid: request was rejected.
- rsp_rdata  out  DATA_W  load result; 0 for stores and errors.
- DM_read  out  1  DM read enable.
- DM_write  out  1  DM write enable.
- DM_addr  out  ADDR_W  word index, req_addr[ADDR_W+1:2].
- DM_in  out  DATA_W  write word.
- DM_out  in  DATA_W  read word; combinational from DM_addr while DM_read=1.

Behaviour:
- Reset (rst=0, async): state=IDLE; rsp_valid=0, rsp_err=0, rsp_rdata=0; DM_read=0, DM_write=0, DM_addr=0, DM_in=0; captured request registers cleared.
- req_ready=1 only in IDLE. A request is accepted when req_valid & req_ready.
- States: IDLE and RMW_WR.

Error check at acceptance:
- Any of these makes the request an error: req_load & req_store both set; neither set; req_size=3; half with addr[0]=1; word with addr[1:0]!=0; word index >= DM_SIZE.
- On error: no DM strobe; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.

Load (all sizes, IDLE, same cycle as acceptance):
- Drive DM_read=1 and DM_addr.
- Select the byte lane by addr[1:0] or the half lane by addr[1].
- Extend per req_signed and register the result.
- Next cycle: rsp_valid=1, rsp_rdata=result. Total latency 1 cycle; stays in IDLE.

Word store (IDLE):
- DM_write=1, DM_in=req_wdata in the acceptance cycle.
- Next cycle: rsp_valid=1. Stays in IDLE.

Sub-word store:
- Acceptance cycle: DM_read=1; merge req_wdata's low byte/half into DM_out at the selected lane; register the merged word, DM_addr and store parameters; go to RMW_WR.
- RMW_WR (req_ready=0): DM_write=1, DM_in=merged word, DM_addr=held index; return to IDLE.
- Next cycle: rsp_valid=1.
- Throughput: one sub-word store every 2 cycles.

Strobe rules:
- DM_read and DM_write are never asserted together.
- Both are 0 whenever no access is in progress.
- DM_read and DM_write are combinational from the state and the accepted request.
- rsp_* outputs are registered.

Boundary conditions:
- Back-to-back requests: a new request may be accepted in the same cycle that rsp_valid pulses for the previous one.
- Store followed immediately by a load to the same word: the load sees the stored value, because DM writes at the edge ending the store cycle.
- Reset asserted in RMW_WR: write abandoned, DM_write drops immediately, no rsp_valid.
- req_valid=0: no strobes, no response.

Decomposition:
- Shared package: size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD), state enum type, DATA_W/ADDR_W defaults mirroring RegBus/DmAddr.
- One natural sub-module, lane_align: combinational byte/half extract+extend for loads and lane merge for stores. Instantiated once for the load path and once for the merge path, or shared with a mode input.

Test Plan:
- Reset release, DM preloaded word0=0x8899AABB. Load byte signed at addr 0x1 -> rsp_rdata=0xFFFFFFAA one cycle later. Same load unsigned -> 0x000000AA.
- Store half 0x1234 at addr 0x6 over DM word1=0xDEADBEEF -> DM_read then DM_write on consecutive cycles; DM word1=0x1234BEEF; req_ready=0 for exactly 1 cycle.
- Word store 0xCAFEF00D to addr 0x10 followed back-to-back by word load from 0x10 -> rsp_rdata=0xCAFEF00D; no stall cycles.
- Misaligned word load at 0x2, half store at 0x3, req_size=3, load+store both set -> each gives rsp_err=1, rsp_rdata=0, no DM strobes.
- Out-of-range load, word index = DM_SIZE -> rsp_err=1.
- rst pulled low during RMW_WR of a byte store 0x55 to addr 0x9 -> DM word2 unchanged; all outputs 0; next request after release works normally.
